// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  localparam int DIV_ITERS = 32;
  localparam int DIV_LAT   = 33;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per clock.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;

  // Trial subtraction; bit WIDTH of the difference is the borrow.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, div_r};
  end

  // Iteration registers: load on start, then one shift/subtract step per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      div_r <= {WIDTH{1'b0}};
    end else if (start) begin
      cnt_r <= ITERS;
      rem_r <= {WIDTH{1'b0}};
      quo_r <= dividend;
      div_r <= divisor;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      if (!trial_s[WIDTH]) begin
        rem_r <= trial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // High during the cycle whose edge performs the final iteration.
  assign done      = (cnt_r == {{(CW-1){1'b0}}, 1'b1});
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_iter_core.sv
// Multi-cycle multiply/divide engine with valid/ready on both sides.
// Optional macro MULDIV_FLUSH_EN adds an in_flush cancel input.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef MULDIV_FLUSH_EN
  input  logic             in_flush,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1
);

  state_t             state_r, state_next_s;
  logic [3:0]         mul_cnt_r;
  logic [2*WIDTH-1:0] prod_r, prod_s, ext0_s, ext1_s;
  logic [WIDTH-1:0]   src0_raw_r;
  logic               sign0_r, sign1_r, div_zero_r;
  logic [WIDTH-1:0]   res0_r, res1_r, res0_next_s, res1_next_s;
  logic               out_valid_r;
  logic               flush_s, accept_s, div_start_s, div_done_s;
  logic [WIDTH-1:0]   abs0_s, abs1_s, div_quo_s, div_rem_s;

`ifdef MULDIV_FLUSH_EN
  assign flush_s = in_flush;
`else
  assign flush_s = 1'b0;
`endif

  assign in_ready    = (state_r == ST_IDLE);
  assign accept_s    = in_valid && in_ready && !flush_s &&
                       ((in_op == OP_MUL) || (in_op == OP_DIV));
  assign div_start_s = accept_s && (in_op == OP_DIV);

  // Operand extension, full-width product and divide magnitudes.
  always_comb begin
    ext0_s = {{WIDTH{in_sign & in_src0[WIDTH-1]}}, in_src0};
    ext1_s = {{WIDTH{in_sign & in_src1[WIDTH-1]}}, in_src1};
    prod_s = ext0_s * ext1_s;
    abs0_s = (in_sign && in_src0[WIDTH-1]) ? ({WIDTH{1'b0}} - in_src0) : in_src0;
    abs1_s = (in_sign && in_src1[WIDTH-1]) ? ({WIDTH{1'b0}} - in_src1) : in_src1;
  end

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .dividend  (abs0_s),
    .divisor   (abs1_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Next-state logic; a flush overrides everything, including an accept.
  always_comb begin
    state_next_s = state_r;
    if (flush_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_next_s = (in_op == OP_MUL) ? ST_MUL : ST_DIV;
          else          state_next_s = ST_IDLE;
        end
        ST_MUL:  state_next_s = (mul_cnt_r == 4'd0) ? ST_DONE : ST_MUL;
        ST_DIV:  state_next_s = div_done_s ? ST_FIX : ST_DIV;
        ST_FIX:  state_next_s = ST_DONE;
        ST_DONE: state_next_s = out_ready ? ST_IDLE : ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Result capture on entry to DONE; divide-by-zero bypasses the sign fixup.
  always_comb begin
    res0_next_s = res0_r;
    res1_next_s = res1_r;
    if ((state_next_s == ST_DONE) && (state_r == ST_MUL)) begin
      res0_next_s = prod_r[WIDTH-1:0];
      res1_next_s = prod_r[2*WIDTH-1:WIDTH];
    end else if ((state_next_s == ST_DONE) && (state_r == ST_FIX)) begin
      if (div_zero_r) begin
        res0_next_s = {WIDTH{1'b1}};
        res1_next_s = src0_raw_r;
      end else begin
        res0_next_s = (sign0_r ^ sign1_r) ? ({WIDTH{1'b0}} - div_quo_s) : div_quo_s;
        res1_next_s = sign0_r ? ({WIDTH{1'b0}} - div_rem_s) : div_rem_s;
      end
    end else begin
      res0_next_s = res0_r;
      res1_next_s = res1_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Operand capture, multiply latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_r      <= {(2*WIDTH){1'b0}};
      mul_cnt_r   <= 4'd0;
      src0_raw_r  <= {WIDTH{1'b0}};
      sign0_r     <= 1'b0;
      sign1_r     <= 1'b0;
      div_zero_r  <= 1'b0;
      res0_r      <= {WIDTH{1'b0}};
      res1_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        prod_r     <= prod_s;
        mul_cnt_r  <= 4'(MUL_LAT - 1);
        src0_raw_r <= in_src0;
        sign0_r    <= in_sign & in_src0[WIDTH-1];
        sign1_r    <= in_sign & in_src1[WIDTH-1];
        div_zero_r <= (in_src1 == {WIDTH{1'b0}});
      end else if ((state_r == ST_MUL) && (mul_cnt_r != 4'd0)) begin
        mul_cnt_r <= mul_cnt_r - 4'd1;
      end
      res0_r      <= res0_next_s;
      res1_r      <= res1_next_s;
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  assign out_valid = out_valid_r;
  assign out_res0  = res0_r;
  assign out_res1  = res1_r;

endmodule

// File: tb/tb_muldiv_iter_core.sv
// Directed, table-driven bench for muldiv_iter_core (MUL_LAT=5, WIDTH=32).
module tb_muldiv_iter_core;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_src0, in_src1;
  logic [1:0]  in_op;
  logic        in_sign, in_valid, in_ready;
  logic        in_flush;
  logic        out_ready, out_valid;
  logic [31:0] out_res0, out_res1;

  always #5 clk = ~clk;

  muldiv_iter_core #(.MUL_LAT(5), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_src0   (in_src0),
    .in_src1   (in_src1),
    .in_op     (in_op),
    .in_sign   (in_sign),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MULDIV_FLUSH_EN
    .in_flush  (in_flush),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_res0  (out_res0),
    .out_res1  (out_res1)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e0;
    logic [31:0] e1;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, count edges to out_valid, check results and handshake.
  task automatic run_vec(input vec_t v);
    int n;
    bit busy_ok;
    check({v.name, "_ready_before"}, 64'(in_ready), 64'd1);
    in_op = v.op; in_sign = v.sgn; in_src0 = v.a; in_src1 = v.b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_op = OP_NONE; in_sign = ~v.sgn;
    in_src0 = 32'hDEAD_BEEF; in_src1 = 32'h0BAD_F00D;
    n = 0; busy_ok = 1'b1;
    while (!out_valid && n < 60) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      n++;
    end
    check({v.name, "_latency"}, 64'(n), 64'(v.lat));
    check({v.name, "_busy"}, 64'(busy_ok), 64'd1);
    check({v.name, "_res0"}, 64'(out_res0), 64'(v.e0));
    check({v.name, "_res1"}, 64'(out_res1), 64'(v.e1));
    step();
    check({v.name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({v.name, "_hold_res0"}, 64'(out_res0), 64'(v.e0));
  endtask

  initial begin
    int n;
    bit quiet;
    vecs[0]  = '{"smul_neg2x3",   OP_MUL, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 5};
    vecs[1]  = '{"umul_neg2x3",   OP_MUL, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'h0000_0002, 5};
    vecs[2]  = '{"smul_7xneg3",   OP_MUL, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 5};
    vecs[3]  = '{"umul_max",      OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[4]  = '{"sdiv_neg7_2",   OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vecs[5]  = '{"udiv_big_2",    OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 33};
    vecs[6]  = '{"sdiv_overflow", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33};
    vecs[7]  = '{"udiv_by_zero",  OP_DIV, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 33};
    vecs[8]  = '{"sdiv_by_zero",  OP_DIV, 1'b1, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 33};
    vecs[9]  = '{"sdiv_100_neg7", OP_DIV, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 33};
    vecs[10] = '{"udiv_100_7",    OP_DIV, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 33};
    vecs[11] = '{"sdiv_neg100_neg7", OP_DIV, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 33};

    reset = 1'b0; in_valid = 1'b0; in_op = OP_NONE; in_sign = 1'b0;
    in_src0 = 32'h0; in_src1 = 32'h0; out_ready = 1'b1; in_flush = 1'b0;
    step(); step();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_res0", 64'(out_res0), 64'd0);
    check("reset_res1", 64'(out_res1), 64'd0);
    reset = 1'b1;
    step();

    // Ops 00 and 11 are never accepted.
    in_valid = 1'b1; in_op = 2'b00; in_src0 = 32'd5; in_src1 = 32'd3;
    step();
    check("op00_in_ready", 64'(in_ready), 64'd1);
    in_op = 2'b11;
    step();
    check("op11_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();
    check("op_reserved_no_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-pressure: results held in DONE, new requests ignored.
    out_ready = 1'b0;
    in_op = OP_MUL; in_sign = 1'b1; in_src0 = 32'h0000_0007; in_src1 = 32'hFFFF_FFFD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin step(); n++; end
    check("bp_latency", 64'(n), 64'd5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = OP_DIV; in_sign = 1'b0; in_src0 = 32'(i + 100); in_src1 = 32'd3;
      step();
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_res", {out_res1, out_res0}, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
      step();
    end
    check("bp_not_queued", 64'(quiet), 64'd1);

    // Reset during divide iteration 10.
    in_op = OP_DIV; in_sign = 1'b0; in_src0 = 32'h0000_1234; in_src1 = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("rst_mid_busy", 64'(in_ready), 64'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_res", {out_res1, out_res0}, 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      step();
    end
    check("rst_mid_no_late_valid", 64'(quiet), 64'd1);

`ifdef MULDIV_FLUSH_EN
    run_vec(vecs[10]);
    in_op = OP_DIV; in_sign = 1'b0; in_src0 = 32'h0000_1234; in_src1 = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_res_kept", {out_res1, out_res0}, 64'h0000_0002_0000_000E);
    in_op = OP_MUL; in_sign = 1'b0; in_src0 = 32'd2; in_src1 = 32'd3; in_valid = 1'b1; in_flush = 1'b1;
    step();
    in_valid = 1'b0; in_flush = 1'b0;
    check("flush_drops_accept", 64'(in_ready), 64'd1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      step();
    end
    check("flush_no_late_valid", 64'(quiet), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
